coherence_bus_arbiter: RTL and testbench
========================================

// Module: coherence_bus_arbiter
// PURPOSE
//  Round-robin, class-aware arbiter in front of the MESI coherence bus controller. Picks one L1
//  requester per bus transaction and holds the grant until the controller signals completion.
//  Replaces the fixed lowest-index priority encode with fair rotation plus starvation aging.
// PARAMETERS
//  CPUS         4   number of L1 requesters (power of 2, >=2)
//  STARVE_LIMIT 3   grants to other CPUs a pending CPU tolerates before forced promotion (>=1)
//  TIMEOUT      0   max BUSY cycles before forced release; 0 disables watchdog
// PORTS
//  CLK          in   1            clock
//  nRST         in   1            reset, asynchronous, active-low
//  req_wen      in   CPUS         per-CPU writeback/evict request (dWEN)
//  req_ren      in   CPUS         per-CPU read request (dREN)
//  req_ccwrite  in   CPUS         per-CPU write intent (ccwrite; with ren = RX, alone = INV)
//  txn_done     in   1            bus controller finished the granted transaction (1-cycle pulse)
//  abort_bus    in   1            exception abort; drops current grant
//  grant_valid  out  1            1-cycle pulse: new grant issued
//  grant_cpu    out  $clog2(CPUS) granted CPU id, stable from grant_valid until release
//  grant_onehot out  CPUS         one-hot of grant_cpu while GRANT/BUSY, else 0
//  grant_type   out  2            bus_req_t of granted request
//  busy         out  1            arbiter owns bus (GRANT or BUSY)
//  timeout_err  out  1            1-cycle pulse on watchdog release
// BEHAVIOUR
//  Reset: all outputs 0 (grant_type=REQ_EVICT=0), state ARB_IDLE, rr_ptr=0, all age counters 0.
//  Per-CPU class: wen->REQ_EVICT > ren&ccwrite->REQ_RX > ren->REQ_R > ccwrite->REQ_INV.
//  FSM: ARB_IDLE -> ARB_GRANT (any request) -> ARB_BUSY -> ARB_IDLE (txn_done).
//  ARB_IDLE selection (combinational, registered into outputs):
//   - starved set = pending CPUs with age==STARVE_LIMIT; if nonempty, pick from it, ignoring class.
//   - else highest class with any requester; pick among that class's CPUs.
//   - pick = first set bit scanning rr_ptr, rr_ptr+1, ... mod CPUS.
//  Latency: request sampled in cycle N -> grant_valid=1, busy=1 in cycle N+1 (ARB_GRANT);
//   ARB_BUSY from N+2; grant_cpu/onehot/type held constant throughout.
//  Requesters hold requests until granted; request changes in GRANT/BUSY are ignored.
//  txn_done in ARB_GRANT or ARB_BUSY -> ARB_IDLE next cycle; busy=0 that cycle; no grant
//   issued in the same cycle as release (one idle cycle min between grants).
//  On release by txn_done: rr_ptr <= (grant_cpu+1) mod CPUS; granted CPU age <= 0; every
//   other CPU with a pending request at grant time: age <= min(age+1, STARVE_LIMIT).
//  txn_done in ARB_IDLE ignored.
//  abort_bus (any state, priority over txn_done) -> ARB_IDLE next cycle, outputs cleared,
//   rr_ptr and ages unchanged (aborted CPU may win again).
//  Watchdog (TIMEOUT>0): cycle counter cleared on entry to ARB_GRANT; if it reaches TIMEOUT in
//   ARB_BUSY without txn_done -> timeout_err pulse, release as for txn_done (rr_ptr advances).
//  txn_done and timeout same cycle -> treated as txn_done, timeout_err=0.
//  Async reset mid-transaction clears everything immediately; no partial grant survives.
// STRUCTURE
//  Shared package (coherence_pkg): bus_req_t enum {REQ_EVICT,REQ_RX,REQ_R,REQ_INV}, arb_state_t
//   enum, CPU_ID_LENGTH derivation helper.
//  Sub-module rr_picker #(N): combinational rotating-priority picker (mask, ptr -> valid, idx);
//   instanced twice (starved set, class set); all state lives in coherence_bus_arbiter.
// TESTING
//  1 Fairness: CPUS=4, all req_ren=1 held, txn_done 3 cycles after each grant -> grant_cpu 0,1,2,3,0.
//  2 Class: from idle, same cycle req_ren[2]=1, req_wen[1]=1 -> grant CPU1 REQ_EVICT, then CPU2 REQ_R.
//  3 Starvation: STARVE_LIMIT=2, req_ren[0] held, CPUs1,3 reissue req_wen after each grant ->
//    CPU0 granted after at most 2 other grants.
//  4 Abort: abort_bus in ARB_BUSY with grant_cpu=2 -> next cycle busy=0, onehot=0; CPU2 alone
//    requesting is re-granted (rr_ptr unchanged).
//  5 Watchdog: TIMEOUT=16, grant, no txn_done -> timeout_err pulse at BUSY cycle 16, busy drops,
//    next pending CPU granted; txn_done coincident with timeout -> no timeout_err.
//  6 Reset: nRST low mid-BUSY -> all outputs 0 asynchronously; after release, first grant to
//    lowest-index requester of top class (rr_ptr=0).

Source files
------------

// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared types for the coherence bus arbiter: request classes, arbiter states
// and the CPU id width helper.
package coherence_pkg;
    typedef enum logic [1:0] {
        REQ_EVICT = 2'd0,
        REQ_RX    = 2'd1,
        REQ_R     = 2'd2,
        REQ_INV   = 2'd3
    } bus_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_t;

    // Id width never drops below one bit so a two-CPU system still has a legal id.
    function automatic int cpu_id_length(input int cpus);
        return (cpus > 2) ? $clog2(cpus) : 1;
    endfunction
endpackage

// File: rtl/coherence_bus_arbiter_if.sv
// Request/grant bundle between the L1 requesters, the bus controller and the arbiter.
interface coherence_bus_arbiter_if #(
    parameter int CPUS = 4
);
    import coherence_pkg::*;

    localparam int ID_W = cpu_id_length(CPUS);

    logic [CPUS-1:0] req_wen;
    logic [CPUS-1:0] req_ren;
    logic [CPUS-1:0] req_ccwrite;
    logic            txn_done;
    logic            abort_bus;
    logic            grant_valid;
    logic [ID_W-1:0] grant_cpu;
    logic [CPUS-1:0] grant_onehot;
    bus_req_t        grant_type;
    logic            busy;
    logic            timeout_err;

    modport slave (
        input  req_wen, req_ren, req_ccwrite, txn_done, abort_bus,
        output grant_valid, grant_cpu, grant_onehot, grant_type, busy, timeout_err
    );

    modport master (
        output req_wen, req_ren, req_ccwrite, txn_done, abort_bus,
        input  grant_valid, grant_cpu, grant_onehot, grant_type, busy, timeout_err
    );
endinterface

// File: rtl/coherence_bus_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first set bit of i_mask scanning
// i_ptr, i_ptr+1, ... modulo N (N a power of two).
module rr_picker
    import coherence_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]                i_mask,
    input  logic [cpu_id_length(N)-1:0] i_ptr,
    output logic                        o_valid,
    output logic [cpu_id_length(N)-1:0] o_idx
);
    localparam int IDX_W = cpu_id_length(N);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        // Scan from the farthest offset so the nearest hit after i_ptr is written last.
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = i_ptr + IDX_W'(i);
            if (i_mask[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end
endmodule

// File: rtl/coherence_bus_arbiter.sv
// Class-aware round-robin arbiter with starvation aging and an optional watchdog
// in front of the MESI coherence bus controller.
module coherence_bus_arbiter
    import coherence_pkg::*;
#(
    parameter int CPUS         = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 0
) (
    input  logic                   CLK,
    input  logic                   nRST,
    coherence_bus_arbiter_if.slave bus
);
    localparam int ID_W  = cpu_id_length(CPUS);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [AGE_W-1:0] r_age [CPUS];
    logic [CPUS-1:0] r_pend_snap;
    logic [WD_W-1:0] r_wdog;
    logic            r_grant_valid;
    logic [ID_W-1:0] r_grant_cpu;
    logic [CPUS-1:0] r_grant_onehot;
    bus_req_t        r_grant_type;
    logic            r_busy;
    logic            r_timeout_err;

    logic [CPUS-1:0] w_pend;
    logic [CPUS-1:0] w_starved;
    logic [CPUS-1:0] w_top_mask;
    logic [CPUS-1:0] w_cls_mask [4];
    bus_req_t        w_class [CPUS];
    logic            w_st_valid;
    logic            w_top_valid;
    logic [ID_W-1:0] w_st_idx;
    logic [ID_W-1:0] w_top_idx;
    logic [ID_W-1:0] w_pick;
    logic            w_grant;
    logic            w_release;
    logic            w_to_err;
    logic            w_timeout;

    // Per-CPU class, starved set and the mask of the highest populated class.
    always_comb begin
        w_pend     = '0;
        w_starved  = '0;
        w_top_mask = '0;
        for (int c = 0; c < 4; c++) w_cls_mask[c] = '0;
        for (int i = 0; i < CPUS; i++) begin
            w_class[i]   = REQ_INV;
            w_pend[i]    = bus.req_wen[i] | bus.req_ren[i] | bus.req_ccwrite[i];
            w_starved[i] = w_pend[i] && (r_age[i] == AGE_W'(STARVE_LIMIT));
            if (bus.req_wen[i])                              w_class[i] = REQ_EVICT;
            else if (bus.req_ren[i] && bus.req_ccwrite[i])   w_class[i] = REQ_RX;
            else if (bus.req_ren[i])                         w_class[i] = REQ_R;
            w_cls_mask[w_class[i]][i] = w_pend[i];
        end
        for (int c = 3; c >= 0; c--) begin
            if (|w_cls_mask[c]) w_top_mask = w_cls_mask[c];
        end
    end

    rr_picker #(.N(CPUS)) u_pick_starved (
        .i_mask  (w_starved),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_st_valid),
        .o_idx   (w_st_idx)
    );

    rr_picker #(.N(CPUS)) u_pick_class (
        .i_mask  (w_top_mask),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_top_valid),
        .o_idx   (w_top_idx)
    );

    assign w_pick    = w_st_valid ? w_st_idx : w_top_idx;
    assign w_timeout = (TIMEOUT > 0) && (r_state == ARB_BUSY) && (r_wdog == WD_W'(TIMEOUT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= ARB_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Abort wins over everything; txn_done wins over the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_release   = 1'b0;
        w_to_err    = 1'b0;
        if (bus.abort_bus) begin
            w_state_nxt = ARB_IDLE;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_top_valid) begin
                        w_state_nxt = ARB_GRANT;
                        w_grant     = 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if (bus.txn_done) begin
                        w_state_nxt = ARB_IDLE;
                        w_release   = 1'b1;
                    end else begin
                        w_state_nxt = ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (bus.txn_done) begin
                        w_state_nxt = ARB_IDLE;
                        w_release   = 1'b1;
                    end else if (w_timeout) begin
                        w_state_nxt = ARB_IDLE;
                        w_release   = 1'b1;
                        w_to_err    = 1'b1;
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_grant_valid  <= 1'b0;
            r_grant_cpu    <= '0;
            r_grant_onehot <= '0;
            r_grant_type   <= REQ_EVICT;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_rr_ptr       <= '0;
            r_pend_snap    <= '0;
            r_wdog         <= '0;
            for (int i = 0; i < CPUS; i++) r_age[i] <= '0;
        end else begin
            r_grant_valid <= w_grant;
            r_timeout_err <= w_to_err;
            if (w_grant) begin
                r_grant_cpu    <= w_pick;
                r_grant_onehot <= CPUS'(1) << w_pick;
                r_grant_type   <= w_class[w_pick];
                r_busy         <= 1'b1;
                r_pend_snap    <= w_pend;
                r_wdog         <= '0;
            end else if (w_state_nxt == ARB_IDLE) begin
                r_grant_cpu    <= '0;
                r_grant_onehot <= '0;
                r_grant_type   <= REQ_EVICT;
                r_busy         <= 1'b0;
            end else begin
                r_wdog <= r_wdog + WD_W'(1);
            end
            // Aging uses the requests seen when the grant was made, not live ones.
            if (w_release) begin
                r_rr_ptr <= r_grant_cpu + ID_W'(1);
                for (int i = 0; i < CPUS; i++) begin
                    if (ID_W'(i) == r_grant_cpu)
                        r_age[i] <= '0;
                    else if (r_pend_snap[i] && (r_age[i] != AGE_W'(STARVE_LIMIT)))
                        r_age[i] <= r_age[i] + AGE_W'(1);
                end
            end
        end
    end

    assign bus.grant_valid  = r_grant_valid;
    assign bus.grant_cpu    = r_grant_cpu;
    assign bus.grant_onehot = r_grant_onehot;
    assign bus.grant_type   = r_grant_type;
    assign bus.busy         = r_busy;
    assign bus.timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Randomized and directed bench for coherence_bus_arbiter against a
// transaction-level reference model.
module tb_coherence_bus_arbiter;
    import coherence_pkg::*;

    localparam int CPUS    = 4;
    localparam int LIMIT   = 2;
    localparam int TIMEOUT = 16;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    coherence_bus_arbiter_if #(.CPUS(CPUS)) bus ();

    coherence_bus_arbiter #(
        .CPUS         (CPUS),
        .STARVE_LIMIT (LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the bus, since when, and the fairness bookkeeping.
    int            m_owner;
    int            m_type;
    int            m_rr;
    int            m_elapsed;
    int            m_age [CPUS];
    bit [CPUS-1:0] m_snap;
    bit            m_valid;
    bit            m_terr;

    int fair_exp   [5] = '{0, 1, 2, 3, 0};
    int starve_exp [3] = '{1, 3, 0};

    function automatic int cls_of(input int i);
        if (bus.req_wen[i])                        return 0;
        if (bus.req_ren[i] && bus.req_ccwrite[i])  return 1;
        if (bus.req_ren[i])                        return 2;
        if (bus.req_ccwrite[i])                    return 3;
        return -1;
    endfunction

    function automatic int rr_first(input bit [CPUS-1:0] cand);
        for (int k = 0; k < CPUS; k++)
            if (cand[(m_rr + k) % CPUS]) return (m_rr + k) % CPUS;
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = -1; m_type = 0; m_rr = 0; m_elapsed = 0;
        m_snap = '0; m_valid = 1'b0; m_terr = 1'b0;
        for (int i = 0; i < CPUS; i++) m_age[i] = 0;
    endtask

    task automatic m_release();
        for (int i = 0; i < CPUS; i++) begin
            if (i == m_owner)  m_age[i] = 0;
            else if (m_snap[i]) m_age[i] = (m_age[i] + 1 > LIMIT) ? LIMIT : m_age[i] + 1;
        end
        m_rr    = (m_owner + 1) % CPUS;
        m_owner = -1;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit [CPUS-1:0] starved;
        bit [CPUS-1:0] top;
        int best;
        m_valid = 1'b0;
        m_terr  = 1'b0;
        if (!nRST) begin
            m_reset();
        end else if (bus.abort_bus) begin
            m_owner = -1;
        end else if (m_owner < 0) begin
            best = 4;
            for (int i = 0; i < CPUS; i++)
                if (cls_of(i) >= 0 && cls_of(i) < best) best = cls_of(i);
            if (best < 4) begin
                starved = '0; top = '0;
                for (int i = 0; i < CPUS; i++) begin
                    m_snap[i]  = (cls_of(i) >= 0);
                    starved[i] = m_snap[i] && (m_age[i] == LIMIT);
                    top[i]     = (cls_of(i) == best);
                end
                m_owner   = (starved != 0) ? rr_first(starved) : rr_first(top);
                m_type    = cls_of(m_owner);
                m_elapsed = 0;
                m_valid   = 1'b1;
            end
        end else if (bus.txn_done) begin
            m_release();
        end else if (m_elapsed >= 1 && m_elapsed == TIMEOUT) begin
            m_release();
            m_terr = 1'b1;
        end else begin
            m_elapsed++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @vec %0d: got %0h expected %0h", name, n_vec, act, exp);
        end
    endtask

    task automatic compare();
        logic            ebusy;
        logic [CPUS-1:0] eoh;
        ebusy = (m_owner >= 0);
        eoh   = ebusy ? (CPUS'(1) << m_owner) : '0;
        check("busy",         32'(bus.busy),         32'(ebusy));
        check("grant_valid",  32'(bus.grant_valid),  32'(m_valid));
        check("timeout_err",  32'(bus.timeout_err),  32'(m_terr));
        check("grant_cpu",    32'(bus.grant_cpu),    ebusy ? m_owner : 0);
        check("grant_onehot", 32'(bus.grant_onehot), 32'(eoh));
        check("grant_type",   32'(bus.grant_type),   ebusy ? m_type : 0);
    endtask

    task automatic step();
        model_update();
        @(posedge CLK);
        #1;
        n_vec++;
        compare();
    endtask

    task automatic clear_inputs();
        bus.req_wen = '0; bus.req_ren = '0; bus.req_ccwrite = '0;
        bus.txn_done = 1'b0; bus.abort_bus = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        repeat (3) step();
        nRST = 1'b1;
    endtask

    task automatic pulse_done();
        bus.txn_done = 1'b1;
        step();
        bus.txn_done = 1'b0;
    endtask

    task automatic wait_grant(output int cpu, output int typ);
        int n;
        n = 0; cpu = -1; typ = -1;
        while (bus.grant_valid !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        if (bus.grant_valid !== 1'b1) begin
            n_err++;
            $display("FAIL grant_wait: grant_valid=%b after %0d cycles, required 1", bus.grant_valid, n);
        end else begin
            cpu = int'(bus.grant_cpu);
            typ = int'(bus.grant_type);
        end
    endtask

    initial begin
        int cpu, typ, n;
        m_reset();
        do_reset();

        // Fairness: everyone reads continuously.
        bus.req_ren = '1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(cpu, typ);
            check($sformatf("fair_cpu%0d", g), cpu, fair_exp[g]);
            repeat (3) step();
            pulse_done();
        end

        // Class precedence: evict beats read.
        do_reset();
        bus.req_ren[2] = 1'b1; bus.req_wen[1] = 1'b1;
        wait_grant(cpu, typ);
        check("class_first_cpu", cpu, 1);
        check("class_first_type", typ, 0);
        bus.req_wen[1] = 1'b0;
        step();
        pulse_done();
        wait_grant(cpu, typ);
        check("class_second_cpu", cpu, 2);
        check("class_second_type", typ, 2);
        bus.req_ren[2] = 1'b0;
        pulse_done();

        // Starvation: a reader against two persistent evictors.
        do_reset();
        bus.req_ren[0] = 1'b1; bus.req_wen[1] = 1'b1; bus.req_wen[3] = 1'b1;
        for (int g = 0; g < 3; g++) begin
            wait_grant(cpu, typ);
            check($sformatf("starve_cpu%0d", g), cpu, starve_exp[g]);
            step();
            pulse_done();
        end

        // Abort keeps the rotation pointer, so CPU2 wins over CPU3 again.
        do_reset();
        bus.req_ren[2] = 1'b1;
        wait_grant(cpu, typ);
        check("abort_pre_cpu", cpu, 2);
        step(); step();
        bus.abort_bus = 1'b1; bus.req_ren[3] = 1'b1;
        step();
        bus.abort_bus = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_onehot", 32'(bus.grant_onehot), 0);
        wait_grant(cpu, typ);
        check("abort_regrant_cpu", cpu, 2);
        pulse_done();

        // Watchdog release, then txn_done coincident with the timeout.
        do_reset();
        bus.req_ren[1] = 1'b1;
        wait_grant(cpu, typ);
        check("wd_first_cpu", cpu, 1);
        bus.req_ren[1] = 1'b0; bus.req_ren[3] = 1'b1;
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("wd_cycles_to_err", n, 17);
        check("wd_busy_at_err", 32'(bus.busy), 0);
        wait_grant(cpu, typ);
        check("wd_next_cpu", cpu, 3);
        bus.req_ren[3] = 1'b0;
        repeat (16) step();
        pulse_done();
        check("wd_coincident_err", 32'(bus.timeout_err), 0);
        check("wd_coincident_busy", 32'(bus.busy), 0);

        // Asynchronous reset in the middle of a transaction.
        do_reset();
        bus.req_ren[0] = 1'b1;
        wait_grant(cpu, typ);
        bus.req_ren[0] = 1'b0;
        pulse_done();
        bus.req_ren[1] = 1'b1;
        wait_grant(cpu, typ);
        check("rst_pre_cpu", cpu, 1);
        bus.req_ren[1] = 1'b0;
        step(); step();
        #3;
        nRST = 1'b0;
        #1;
        check("rst_async_busy", 32'(bus.busy), 0);
        check("rst_async_onehot", 32'(bus.grant_onehot), 0);
        check("rst_async_cpu", 32'(bus.grant_cpu), 0);
        m_reset();
        repeat (2) step();
        nRST = 1'b1;
        bus.req_ren = 4'b1101; bus.req_ccwrite = 4'b1100;
        wait_grant(cpu, typ);
        check("rst_first_cpu", cpu, 2);
        check("rst_first_type", typ, 1);
        clear_inputs();
        pulse_done();

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < CPUS; i++) begin
                bus.req_wen[i]     = ($urandom_range(7) == 0);
                bus.req_ren[i]     = ($urandom_range(2) == 0);
                bus.req_ccwrite[i] = ($urandom_range(4) == 0);
            end
            bus.txn_done  = ($urandom_range(3) == 0);
            bus.abort_bus = ($urandom_range(39) == 0);
            step();
        end
        clear_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
